// File: rtl/uart_pkg.sv
// UART shared definitions: bit timing helpers and receiver FSM states.
// Optional build macro UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

    localparam int CLOCK_FREQ_DEF = 50_000_000;
    localparam int BAUD_RATE_DEF  = 115_200;

    // Whole clock cycles per bit; the remainder is dropped.
    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ_DEF, BAUD_RATE_DEF);
    localparam int SAMPLE_POINT   = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: DEPTH x 8, pointers one bit wider than the address so
// full and empty fall out of the pointer difference.
module uart_rx_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop on an empty FIFO is ignored; a push while full only lands if the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointers and storage write.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Storage and pointer registers; storage is cleared so data_out resets to 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive front-end: 2-flop synchroniser, mid-bit sampling FSM, byte
// shifter, sticky error flags and a ready/valid receive FIFO.
// Build macro UART_RX_PARITY_EN selects 8E1 frames; default is 8N1.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEF,
    parameter int BAUD_RATE  = BAUD_RATE_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow,
    input  logic                          err_clr
);

    localparam int CPB = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] SP_C   = CW'(CPB / 2);
    localparam logic [CW-1:0] LAST_C = CW'(CPB - 1);

    rx_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;
    logic        rx_s, push, fe_set, ovf_set;
    logic        fifo_full, fifo_empty;

    assign rx_s = sync2_q;

    // Synchroniser chain for the asynchronous line.
    always_comb begin
        sync1_d = serial_in;
        sync2_d = sync1_q;
    end

    // Frame FSM: every state samples at mid-bit (SP_C) and wraps its bit period at LAST_C.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == SP_C && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_C) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == SP_C) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                end
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 4'd8) state_d = PARITY;
`else
                    if (bit_q == 4'd8) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == SP_C && rx_s != (^shift_q)) begin
                    fe_set  = 1'b1;
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_C) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (cnt_q == SP_C) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A completed byte with nowhere to go: full and the head is not leaving this cycle.
    assign ovf_set = push && fifo_full && !data_out_ready;

    // Sticky flags; a set in the same cycle as err_clr wins.
    always_comb begin
        frame_err_d = frame_err_q;
        overflow_d  = overflow_q;
        if (err_clr) begin
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
        if (fe_set)  frame_err_d = 1'b1;
        if (ovf_set) overflow_d  = 1'b1;
    end

    // State registers; the synchroniser resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shift_q),
        .pop   (data_out_ready),
        .dout  (data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_out_valid = !fifo_empty;
    assign frame_err      = frame_err_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames,
// compared against a queue-based model of the receive FIFO and sticky flags.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 62_500;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    // Edges from the one that first samples the start bit to the one that raises valid.
    localparam int LAT = 2 + (19 * CPB) / 2 + 1 + (NBITS - 10) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overflow;

    int          n_chk = 0;
    int          n_err = 0;
    byte unsigned mq[$];
    bit          m_fe = 1'b0;
    bit          m_ov = 1'b0;

    always #5 clk = ~clk;

    uart_receiver #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .fifo_count     (fifo_count),
        .frame_err      (frame_err),
        .overflow       (overflow),
        .err_clr        (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, fifo_count, mq.size());
        check({tag, ".valid"}, data_out_valid, mq.size() > 0);
        if (mq.size() > 0) check({tag, ".head"}, data_out, mq[0]);
        check({tag, ".ferr"}, frame_err, m_fe);
        check({tag, ".ovf"}, overflow, m_ov);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Model of one frame's effect; pop/clr describe what the sender did on the push cycle.
    task automatic model_frame(input byte unsigned d, input bit stop_ok, input bit bad_par,
                               input bit pop, input bit clr);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (clr) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        if (!stop_ok || (PAR_EN && bad_par)) m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else m_ov = 1'b1;
    endtask

    // Drive one frame starting at the current negedge; rise_n = negedge index where valid first rises.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit bad_par,
                              input bit pop_at_push, input bit clr_at_push, input int rst_at,
                              output int rise_n);
        logic [NBITS:0] bits;
        logic           prev;
        bits          = '1;
        bits[0]       = 1'b0;
        bits[8:1]     = d;
        if (PAR_EN) bits[9] = (^d) ^ bad_par;
        bits[NBITS-1] = stop_bit;
        rise_n        = -1;
        prev          = data_out_valid;
        serial_in     = bits[0];
        for (int n = 1; n <= NBITS * CPB; n++) begin
            @(negedge clk);
            if (rise_n < 0 && data_out_valid && !prev) rise_n = n;
            prev           = data_out_valid;
            if (n % CPB == 0) serial_in = bits[n / CPB];
            data_out_ready = pop_at_push && (n == LAT);
            err_clr        = clr_at_push && (n == LAT);
            rst            = (n != rst_at);
        end
        data_out_ready = 1'b0;
        err_clr        = 1'b0;
        rst            = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop_ok);
        int r;
        send_frame(d, stop_ok, 1'b0, 1'b0, 1'b0, -1, r);
        model_frame(d, stop_ok, 1'b0, 1'b0, 1'b0);
        if (!stop_ok) idle(2 * CPB);
    endtask

    task automatic pop_one(input string tag);
        check({tag, ".pophead"}, data_out, mq[0]);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        void'(mq.pop_front());
        check_state(tag);
    endtask

    task automatic pulse_clr(input string tag);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        check_state(tag);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // Reset state
        repeat (3) @(negedge clk);
        check_state("reset");
        check("reset.data", data_out, 8'h00);
        rst = 1'b1;
        idle(4);

        // Single byte and its latency
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, -1, r);
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat", r, LAT + 1);
        check_state("a5");
        pop_one("a5pop");

        // Short glitch on idle line: nothing happens, next frame still received
        serial_in = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        idle(2 * CPB);
        check_state("glitch");
        send(8'h5A, 1'b1);
        check_state("postglitch");
        pop_one("postglitchpop");

        // Nine bytes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) send(8'(i), 1'b1);
        check_state("ovf");
        for (int i = 0; i < 8; i++) pop_one("drain");
        pulse_clr("ovfclr");

        // Stop bit low, then recovery
        send(8'h3C, 1'b0);
        check_state("stoplow");
        pulse_clr("ferrclr");
        send(8'h3C, 1'b1);
        check_state("3cok");
        pop_one("3cpop");

        // Set wins over same-cycle clear
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1, r);
        model_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2 * CPB);
        check_state("setwins");
        pulse_clr("setwinsclr");

        // Full FIFO with a pop on the push cycle
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1);
        send_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0, -1, r);
        model_frame(8'h99, 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("fullpop");
        for (int i = 0; i < 8; i++) pop_one("fulldrain");

        // Bad parity (only meaningful in the parity build)
        if (PAR_EN) begin
            send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, -1, r);
            model_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
            idle(2 * CPB);
            check_state("badpar");
            pulse_clr("badparclr");
        end

        // Reset in the middle of data bit 4
        send(8'h42, 1'b1);
        send(8'h00, 1'b0);
        check_state("prerst");
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 5 * CPB + CPB / 2, r);
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check_state("midrst");
        check("midrst.data", data_out, 8'h00);
        send(8'h81, 1'b1);
        check_state("81");
        pop_one("81pop");

        // Random frames, errors, pops and clears
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
            check_state("rnd");
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) pop_one("rndpop");
            if ($urandom_range(0, 5) == 0) pulse_clr("rndclr");
        end
        while (mq.size() > 0) pop_one("rnddrain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
